// File: rtl/rv32i_types.sv
// Shared RV32I core types: load funct3 encodings and the writeback entry record.
package rv32i_types;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int XLEN_DEF   = 32;
  localparam int PREG_W_DEF = 6;
  localparam int ROB_W_DEF  = 5;

  // Default-width writeback record; wb_arbiter rebuilds it from its own parameters.
  typedef struct packed {
    logic                  we;
    logic [PREG_W_DEF-1:0] tag;
    logic [ROB_W_DEF-1:0]  rob;
    logic [XLEN_DEF-1:0]   data;
  } wb_entry_t;

  function automatic int wrap_inc(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-channel result FIFO: power-of-2 depth, generic entry type, sync clear.
module wb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are AW bits wide, so +1 wraps at DEPTH on its own.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: per-channel FIFOs, round-robin grant onto NUM_WP ports, load align.
// Optional WB_STALL_CNT_EN adds per-channel saturating stall counters.
module wb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_CH     = 4,
  parameter int NUM_WP     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32,
  parameter int PREG_W     = 6,
  parameter int ROB_W      = 5,
  parameter int LOAD_CH    = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [NUM_CH-1:0]              ch_valid,
  output logic [NUM_CH-1:0]              ch_ready,
  input  logic [NUM_CH-1:0]              ch_we,
  input  logic [NUM_CH-1:0][PREG_W-1:0]  ch_tag,
  input  logic [NUM_CH-1:0][ROB_W-1:0]   ch_rob,
  input  logic [NUM_CH-1:0][XLEN-1:0]    ch_data,
  input  logic [2:0]                     ld_funct3,
  input  logic [1:0]                     ld_addr_lo,
  output logic [NUM_WP-1:0]              wp_valid,
  output logic [NUM_WP-1:0]              wp_we,
  output logic [NUM_WP-1:0][PREG_W-1:0]  wp_tag,
  output logic [NUM_WP-1:0][ROB_W-1:0]   wp_rob,
  output logic [NUM_WP-1:0][XLEN-1:0]    wp_data,
  output logic [63:0]                    commit_cnt
`ifdef WB_STALL_CNT_EN
  ,
  output logic [NUM_CH-1:0][15:0]        stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic              we;
    logic [PREG_W-1:0] tag;
    logic [ROB_W-1:0]  rob;
    logic [XLEN-1:0]   data;
  } entry_t;

  entry_t [NUM_CH-1:0]          enq, head;
  logic   [NUM_CH-1:0]          push, pop, full, empty, grant;
  logic   [NUM_CH-1:0][CW-1:0]  count;
  logic   [NUM_WP-1:0][PW-1:0]  port_sel;
  logic   [NUM_WP-1:0]          port_used;
  int                           n_gnt, last_ch;

  logic [PW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [63:0]                 commit_cnt_q, commit_cnt_d;
  logic [NUM_WP-1:0]           wp_valid_q, wp_valid_d, wp_we_q, wp_we_d;
  logic [NUM_WP-1:0][PREG_W-1:0] wp_tag_q, wp_tag_d;
  logic [NUM_WP-1:0][ROB_W-1:0]  wp_rob_q, wp_rob_d;
  logic [NUM_WP-1:0][XLEN-1:0]   wp_data_q, wp_data_d;

  // Load alignment happens before the FIFO so heads are already final data.
  logic [XLEN-1:0] ld_word, ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  always_comb begin
    ld_word = ch_data[LOAD_CH];
    ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      F3_LW:   ld_data = ld_word;
      default: ld_data = '0;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign enq[i]      = {ch_we[i], ch_tag[i], ch_rob[i],
                          (i == LOAD_CH) ? ld_data : ch_data[i]};
    assign ch_ready[i] = rst_n && !flush && (count[i] != FULL_CNT);
    assign push[i]     = ch_valid[i] && ch_ready[i] && !full[i];

    wb_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (enq[i]),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (count[i])
    );
  end

  // Scan from rr_ptr, handing ports out in scan order until they run out.
  always_comb begin
    int idx;
    grant     = '0;
    port_sel  = '0;
    port_used = '0;
    n_gnt     = 0;
    last_ch   = int'(rr_ptr_q);
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!empty[idx] && n_gnt < NUM_WP) begin
        grant[idx]       = 1'b1;
        port_sel[n_gnt]  = PW'(idx);
        port_used[n_gnt] = 1'b1;
        last_ch          = idx;
        n_gnt            = n_gnt + 1;
      end
    end
  end

  always_comb begin
    pop          = '0;
    wp_valid_d   = '0;
    wp_we_d      = '0;
    wp_tag_d     = wp_tag_q;
    wp_rob_d     = wp_rob_q;
    wp_data_d    = wp_data_q;
    rr_ptr_d     = rr_ptr_q;
    commit_cnt_d = commit_cnt_q;
    if (!flush) begin
      pop = grant;
      for (int p = 0; p < NUM_WP; p++) begin
        if (port_used[p]) begin
          wp_valid_d[p] = 1'b1;
          wp_we_d[p]    = head[port_sel[p]].we;
          wp_tag_d[p]   = head[port_sel[p]].tag;
          wp_rob_d[p]   = head[port_sel[p]].rob;
          wp_data_d[p]  = head[port_sel[p]].we ? head[port_sel[p]].data : '0;
        end
      end
      if (|grant) rr_ptr_d = PW'(wrap_inc(last_ch, NUM_CH));
      commit_cnt_d = commit_cnt_q + 64'(n_gnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      commit_cnt_q <= '0;
      wp_valid_q   <= '0;
      wp_we_q      <= '0;
      wp_tag_q     <= '0;
      wp_rob_q     <= '0;
      wp_data_q    <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      commit_cnt_q <= commit_cnt_d;
      wp_valid_q   <= wp_valid_d;
      wp_we_q      <= wp_we_d;
      wp_tag_q     <= wp_tag_d;
      wp_rob_q     <= wp_rob_d;
      wp_data_q    <= wp_data_d;
    end
  end

  assign wp_valid   = wp_valid_q;
  assign wp_we      = wp_we_q;
  assign wp_tag     = wp_tag_q;
  assign wp_rob     = wp_rob_q;
  assign wp_data    = wp_data_q;
  assign commit_cnt = commit_cnt_q;

`ifdef WB_STALL_CNT_EN
  logic [NUM_CH-1:0][15:0] stall_cnt_q, stall_cnt_d;

  // Survives flush on purpose: it measures arbitration pressure across flushes.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!empty[i] && !grant[i] && stall_cnt_q[i] != 16'hFFFF)
        stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default 4 channels, 2 write ports).
module tb_wb_arbiter;

  localparam int NUM_CH = 4, NUM_WP = 2, FIFO_DEPTH = 4;
  localparam int XLEN = 32, PREG_W = 6, ROB_W = 5, LOAD_CH = 0;

  logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
  logic [NUM_CH-1:0]             ch_valid, ch_ready, ch_we;
  logic [NUM_CH-1:0][PREG_W-1:0] ch_tag;
  logic [NUM_CH-1:0][ROB_W-1:0]  ch_rob;
  logic [NUM_CH-1:0][XLEN-1:0]   ch_data;
  logic [2:0]                    ld_funct3;
  logic [1:0]                    ld_addr_lo;
  logic [NUM_WP-1:0]             wp_valid, wp_we;
  logic [NUM_WP-1:0][PREG_W-1:0] wp_tag;
  logic [NUM_WP-1:0][ROB_W-1:0]  wp_rob;
  logic [NUM_WP-1:0][XLEN-1:0]   wp_data;
  logic [63:0]                   commit_cnt;
`ifdef WB_STALL_CNT_EN
  logic [NUM_CH-1:0][15:0]       stall_cnt;
`endif

  int          n_vec = 0, n_fail = 0;
  logic [63:0] exp_cnt = '0;

  wb_arbiter #(
    .NUM_CH(NUM_CH), .NUM_WP(NUM_WP), .FIFO_DEPTH(FIFO_DEPTH), .XLEN(XLEN),
    .PREG_W(PREG_W), .ROB_W(ROB_W), .LOAD_CH(LOAD_CH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_we(ch_we),
    .ch_tag(ch_tag), .ch_rob(ch_rob), .ch_data(ch_data),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .wp_valid(wp_valid), .wp_we(wp_we), .wp_tag(wp_tag), .wp_rob(wp_rob),
    .wp_data(wp_data), .commit_cnt(commit_cnt)
`ifdef WB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    ch_valid   = '0;
    ch_we      = '0;
    ch_tag     = '0;
    ch_rob     = '0;
    ch_data    = '0;
    ld_funct3  = 3'b010;
    ld_addr_lo = 2'd0;
    flush      = 1'b0;
  endtask

  // Every channel valid with we=1, tag 8+i, data i.
  task automatic drive_all();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_valid[i] = 1'b1;
      ch_we[i]    = 1'b1;
      ch_tag[i]   = PREG_W'(8 + i);
      ch_rob[i]   = ROB_W'(i);
      ch_data[i]  = XLEN'(i);
    end
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    #2;
    n_vec++; if (ch_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %h exp 0", ch_ready); end
    n_vec++; if (wp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b exp 00", wp_valid); end
    n_vec++; if (wp_we !== 2'b00) begin n_fail++; $display("FAIL reset_we: got %b exp 00", wp_we); end
    n_vec++; if (commit_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", commit_cnt); end
    n_vec++; if (wp_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", wp_data); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (ch_ready !== 4'hF) begin n_fail++; $display("FAIL reset_release_ready: got %h exp f", ch_ready); end
  endtask

  task automatic test_single();
    ch_valid[1] = 1'b1; ch_we[1] = 1'b1; ch_tag[1] = 6'd5; ch_rob[1] = 5'd3;
    ch_data[1] = 32'hDEADBEEF;
    @(posedge clk); #1 idle();
    @(negedge clk);
    n_vec++; if (wp_valid !== 2'b00) begin n_fail++; $display("FAIL single_early: got %b exp 00", wp_valid); end
    @(posedge clk); @(negedge clk);
    exp_cnt = exp_cnt + 1;
    n_vec++; if (wp_valid !== 2'b01) begin n_fail++; $display("FAIL single_valid: got %b exp 01", wp_valid); end
    n_vec++; if (wp_we !== 2'b01) begin n_fail++; $display("FAIL single_we: got %b exp 01", wp_we); end
    n_vec++; if (wp_tag[0] !== 6'd5) begin n_fail++; $display("FAIL single_tag: got %0d exp 5", wp_tag[0]); end
    n_vec++; if (wp_rob[0] !== 5'd3) begin n_fail++; $display("FAIL single_rob: got %0d exp 3", wp_rob[0]); end
    n_vec++; if (wp_data[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h exp deadbeef", wp_data[0]); end
    n_vec++; if (commit_cnt !== exp_cnt) begin n_fail++; $display("FAIL single_cnt: got %0d exp %0d", commit_cnt, exp_cnt); end
    @(negedge clk);
    n_vec++; if (wp_valid !== 2'b00) begin n_fail++; $display("FAIL single_drop: got %b exp 00", wp_valid); end
    n_vec++; if (wp_tag[0] !== 6'd5) begin n_fail++; $display("FAIL single_hold_tag: got %0d exp 5", wp_tag[0]); end
  endtask

  task automatic test_load();
    logic [2:0]  f3 [10] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    logic [1:0]  lo [10] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3};
    logic [31:0] ex [10] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FF80, 32'h0000_7F80,
                             32'h0000_8001, 32'hFFFF_8001, 32'h8001_7F80, 32'h0000_0000,
                             32'h0000_0080, 32'hFFFF_FF80};
    for (int v = 0; v < 10; v++) begin
      ch_valid[0] = 1'b1; ch_we[0] = 1'b1; ch_tag[0] = 6'd1; ch_rob[0] = ROB_W'(v);
      ch_data[0] = 32'h8001_7F80; ld_funct3 = f3[v]; ld_addr_lo = lo[v];
      @(posedge clk); #1 idle();
      @(posedge clk); @(negedge clk);
      exp_cnt = exp_cnt + 1;
      n_vec++; if (wp_valid !== 2'b01 || wp_data[0] !== ex[v])
        begin n_fail++; $display("FAIL load_%0d: got v=%b d=%h exp v=01 d=%h", v, wp_valid, wp_data[0], ex[v]); end
    end
    n_vec++; if (commit_cnt !== exp_cnt) begin n_fail++; $display("FAIL load_cnt: got %0d exp %0d", commit_cnt, exp_cnt); end
  endtask

  task automatic test_store();
    ch_valid[3] = 1'b1; ch_we[3] = 1'b0; ch_tag[3] = 6'd7; ch_rob[3] = 5'd9;
    ch_data[3] = 32'h1234_5678;
    @(posedge clk); #1 idle();
    @(posedge clk); @(negedge clk);
    exp_cnt = exp_cnt + 1;
    n_vec++; if (wp_valid !== 2'b01) begin n_fail++; $display("FAIL store_valid: got %b exp 01", wp_valid); end
    n_vec++; if (wp_we !== 2'b00) begin n_fail++; $display("FAIL store_we: got %b exp 00", wp_we); end
    n_vec++; if (wp_tag[0] !== 6'd7 || wp_rob[0] !== 5'd9)
      begin n_fail++; $display("FAIL store_tagrob: got %0d/%0d exp 7/9", wp_tag[0], wp_rob[0]); end
    n_vec++; if (wp_data[0] !== 32'd0) begin n_fail++; $display("FAIL store_data: got %h exp 0", wp_data[0]); end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_t0 [3] = '{6'd8, 6'd10, 6'd8};
    logic [5:0] exp_t1 [3] = '{6'd9, 6'd11, 6'd9};
    logic [63:0] base;
    base = exp_cnt;
    drive_all();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 if (k == 2) idle();
      @(negedge clk);
      n_vec++; if (wp_valid !== 2'b11 || wp_we !== 2'b11)
        begin n_fail++; $display("FAIL rr_valid_%0d: got v=%b we=%b exp 11/11", k, wp_valid, wp_we); end
      n_vec++; if (wp_tag[0] !== exp_t0[k] || wp_tag[1] !== exp_t1[k])
        begin n_fail++; $display("FAIL rr_grant_%0d: got %0d,%0d exp %0d,%0d", k, wp_tag[0], wp_tag[1], exp_t0[k], exp_t1[k]); end
      n_vec++; if (commit_cnt !== base + 64'(2 * (k + 1)))
        begin n_fail++; $display("FAIL rr_cnt_%0d: got %0d exp %0d", k, commit_cnt, base + 64'(2 * (k + 1))); end
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    exp_cnt = base + 64'd16;
    n_vec++; if (commit_cnt !== exp_cnt) begin n_fail++; $display("FAIL rr_drain_cnt: got %0d exp %0d", commit_cnt, exp_cnt); end
    n_vec++; if (wp_valid !== 2'b00) begin n_fail++; $display("FAIL rr_drain_valid: got %b exp 00", wp_valid); end
  endtask

  task automatic test_backpressure();
    logic        exp_rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  acc;
    int          seq2, rx2, n_push;
    seq2 = 0; rx2 = 0; n_push = 0;
    drive_all();
    ch_data[2] = 32'h200;
    acc = ch_ready & ch_valid;
    for (int c = 1; c <= 26; c++) begin
      @(posedge clk);
      #1;
      n_push = n_push + $countones(acc);
      if (acc[2]) begin seq2++; ch_data[2] = 32'h200 + 32'(seq2); end
      if (c == 10) idle();
      @(negedge clk);
      if (c <= 8) begin
        n_vec++; if (ch_ready[2] !== exp_rdy[c-1])
          begin n_fail++; $display("FAIL bp_ready_%0d: got %b exp %b", c, ch_ready[2], exp_rdy[c-1]); end
      end
      for (int p = 0; p < NUM_WP; p++) begin
        if (wp_valid[p] && wp_tag[p] == 6'd10) begin
          n_vec++; if (wp_data[p] !== 32'h200 + 32'(rx2))
            begin n_fail++; $display("FAIL bp_order: got %h exp %h", wp_data[p], 32'h200 + 32'(rx2)); end
          rx2++;
        end
      end
      acc = ch_ready & ch_valid;
    end
    exp_cnt = exp_cnt + 64'(n_push);
    n_vec++; if (rx2 !== seq2) begin n_fail++; $display("FAIL bp_count: got %0d exp %0d", rx2, seq2); end
    n_vec++; if (commit_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_cnt: got %0d exp %0d", commit_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    drive_all();
    ch_valid[3] = 1'b0;
    @(posedge clk);
    #1 idle();
    ch_valid[3] = 1'b1; ch_we[3] = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    n_vec++; if (ch_ready !== 4'h0) begin n_fail++; $display("FAIL flush_ready_low: got %h exp 0", ch_ready); end
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    n_vec++; if (wp_valid !== 2'b00 || wp_we !== 2'b00)
      begin n_fail++; $display("FAIL flush_valid: got v=%b we=%b exp 00/00", wp_valid, wp_we); end
    n_vec++; if (ch_ready !== 4'hF) begin n_fail++; $display("FAIL flush_ready: got %h exp f", ch_ready); end
    n_vec++; if (commit_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt: got %0d exp %0d", commit_cnt, exp_cnt); end
    repeat (3) @(negedge clk);
    n_vec++; if (wp_valid !== 2'b00 || commit_cnt !== exp_cnt)
      begin n_fail++; $display("FAIL flush_cleared: got v=%b cnt=%0d exp 00/%0d", wp_valid, commit_cnt, exp_cnt); end
  endtask

  task automatic test_async_reset();
    drive_all();
    @(posedge clk); #1 idle();
    @(posedge clk); @(negedge clk);
    n_vec++; if (wp_valid !== 2'b11) begin n_fail++; $display("FAIL arst_pre_valid: got %b exp 11", wp_valid); end
    n_vec++; if (commit_cnt !== exp_cnt + 64'd2)
      begin n_fail++; $display("FAIL arst_pre_cnt: got %0d exp %0d", commit_cnt, exp_cnt + 64'd2); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (wp_valid !== 2'b00) begin n_fail++; $display("FAIL arst_valid: got %b exp 00", wp_valid); end
    n_vec++; if (commit_cnt !== 64'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d exp 0", commit_cnt); end
    n_vec++; if (ch_ready !== 4'h0) begin n_fail++; $display("FAIL arst_ready: got %h exp 0", ch_ready); end
    n_vec++; if (wp_data !== '0) begin n_fail++; $display("FAIL arst_data: got %h exp 0", wp_data); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (ch_ready !== 4'hF || wp_valid !== 2'b00)
      begin n_fail++; $display("FAIL arst_after: got r=%h v=%b exp f/00", ch_ready, wp_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time budget");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_single();
    test_load();
    test_store();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised writeback stage for the out-of-order core.
- Collects results from NUM_CH functional-unit channels, each buffered in its own FIFO, and grants up to NUM_WP results per cycle onto the physical-regfile write ports / CDB using round-robin.
- Performs load-data alignment and extension for the load channel and counts granted results.
- Sits between the execute units and the physical regfile/ROB.

Parameters:
- NUM_CH, 4, number of result channels
- NUM_WP, 2, number of write ports (1..NUM_CH)
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2)
- XLEN, 32, data width
- PREG_W, 6, physical register tag width
- ROB_W, 5, ROB index width
- LOAD_CH, 0, index of the channel carrying load results

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- ch_valid  in  NUM_CH  result valid per channel
- ch_ready  out  NUM_CH  channel FIFO can accept
- ch_we  in  NUM_CH  result writes a register
- ch_tag  in  NUM_CH*PREG_W  destination physical tag
- ch_rob  in  NUM_CH*ROB_W  ROB index
- ch_data  in  NUM_CH*XLEN  result data (raw dmem word on LOAD_CH)
- ld_funct3  in  3  load type for LOAD_CH (LB/LH/LW/LBU/LHU)
- ld_addr_lo  in  2  dmem_addr[1:0] for LOAD_CH
- wp_valid  out  NUM_WP  port carries a completed result
- wp_we  out  NUM_WP  regfile write enable
- wp_tag  out  NUM_WP*PREG_W  destination tag
- wp_rob  out  NUM_WP*ROB_W  ROB index to mark complete
- wp_data  out  NUM_WP*XLEN  write data
- commit_cnt  out  64  total results granted since reset

Behaviour:
- Reset (rst_n low, asynchronous): all FIFOs empty, rr_ptr=0, wp_valid/wp_we=0, wp_tag/wp_rob/wp_data=0, commit_cnt=0. ch_ready=0 while rst_n is low.
- ch_ready[i] = (count[i] != FIFO_DEPTH) && !flush. Readiness depends only on occupancy; a same-cycle dequeue does not raise ready.
- Enqueue on ch_valid[i] && ch_ready[i]. ch_valid without ready: the producer holds its data, nothing is captured.
- LOAD_CH extraction happens at enqueue:
  - LB/LBU select byte ld_addr_lo; LH/LHU select half ld_addr_lo[1].
  - Sign- or zero-extend to XLEN.
  - LW passes the word unchanged; an undefined funct3 gives 0.
  - Misaligned halves are never presented.
- Arbitration (combinational on FIFO heads): scan channels starting at rr_ptr, wrapping mod NUM_CH. Grant the first NUM_WP non-empty heads, filling ports in scan order (port 0 first).
- Granted heads are dequeued at the same edge. Outputs are registered.
- Latency: minimum 2 cycles from handshake at edge t to wp_valid high in the cycle after edge t+1.
- rr_ptr <= (last granted channel + 1) mod NUM_CH. rr_ptr is unchanged when nothing is granted.
- Entries with we=0 (store, branch) still consume a port: wp_valid=1, wp_we=0, wp_data=0.
- Unused ports: wp_valid=0, wp_we=0, and the other port fields hold their previous values.
- NUM_WP >= NUM_CH: every non-empty head is granted each cycle.
- commit_cnt += number of grants each cycle; wraps modulo 2^64.
- Simultaneous enqueue and dequeue on the same FIFO: count unchanged, ordering preserved.
- Pointers wrap at FIFO_DEPTH.
- flush: at the next edge all FIFOs are cleared and wp_valid/wp_we are set to 0. Grants and enqueues in the flush cycle are discarded and commit_cnt is not incremented. rr_ptr is kept.
- rst_n asserted mid-operation: immediate clear. In-flight results are lost; the upstream pipeline is also reset.

Optional Feature:
- WB_STALL_CNT_EN: adds output stall_cnt (NUM_CH*16).
- Per channel, counts cycles where the FIFO is non-empty but not granted, saturating at 16'hFFFF.
- Cleared by reset only; flush does not clear it.
- Without the macro: no port and no counter logic.

Decomposition:
- rv32i_types gains:
  - wb_entry_t struct {we, tag, rob, data}
  - load funct3 constants (lb, lh, lw, lbu, lhu) if not already present
- wb_fifo is one sub-module, instantiated per channel: parametrised depth and entry type, push/pop/full/empty/count, asynchronous active-low reset, synchronous clear.
- Round-robin scan and load extraction stay in wb_arbiter.

Test Plan:
- Single result: ch1 valid, tag=5, rob=3, data=32'hDEADBEEF, we=1 -> two cycles later port0 shows valid=1, we=1, tag=5, rob=3, data=DEADBEEF; commit_cnt=1.
- Load extraction: LOAD_CH word 32'h8001_7F80 with ld_addr_lo=2:
  - LB -> wp_data=32'h0000_0001
  - LBU -> 32'h0000_0001
  - with ld_addr_lo=0, LB -> 32'hFFFF_FF80, LH -> 32'h0000_7F80
  - LHU with ld_addr_lo=2 -> 32'h0000_8001
- Round-robin: all 4 channels valid every cycle, NUM_WP=2 -> grants alternate {0,1}, {2,3}, {0,1}; commit_cnt advances by 2 per cycle.
- Backpressure: ch2 pushed 5 times with no grants (other channels saturating at higher priority is not possible, so force by holding valid while FIFO fills faster than drains) -> ch_ready[2]=0 exactly when count=4; no entry lost or duplicated.
- Flush: 3 entries queued across channels, flush pulsed for 1 cycle -> wp_valid=0 next cycle, all ch_ready=1 after flush, commit_cnt unchanged.
- Async reset mid-stream: rst_n dropped between edges -> wp_valid, commit_cnt, and ch_ready go to 0 immediately without a clock edge.
